// File: rtl/imem_loader.sv
// imem_loader: parses framed UART bytes (A5, count, data, checksum) into 32-bit
// instruction-memory writes, holding the core in reset until a frame checks out.
module imem_loader #(
  parameter int MEM_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  words_written
);

  localparam int CW = $clog2(MEM_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] START_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE, ERR} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] word_idx_reg, word_idx_next;
  logic [1:0]    byte_idx_reg, byte_idx_next;
  logic [31:0]   asm_reg, asm_next;
  logic [7:0]    csum_reg, csum_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          hold_reg, hold_next;
  logic [6:0]    ww_reg, ww_next;
  logic          we_reg, we_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wd_reg, wd_next;

  logic          lane_we;
  logic          timeout_hit;
  logic          count_ok;
  logic [7:0]    lane_byte [4];
  logic [31:0]   word_assembled;

  assign lane_we     = (state_reg == DATA) && rx_valid;
  assign timeout_hit = !rx_valid && (timer_reg == TW'(TIMEOUT_CYCLES - 1));
  assign count_ok    = (rx_data != 8'd0) && (int'({24'd0, rx_data}) <= MEM_WORDS);

  // Word as it stands including the byte arriving this cycle, so the 4th byte
  // can be written out without an extra cycle of latency.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = (lane_we && byte_idx_reg == 2'(gi)) ? rx_data : asm_reg[8*gi +: 8];
    end
  endgenerate
  assign word_assembled = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    asm_next      = lane_we ? word_assembled : asm_reg;
    csum_next     = csum_reg;
    timer_next    = '0;
    done_next     = done_reg;
    err_next      = err_reg;
    hold_next     = hold_reg;
    ww_next       = ww_reg;
    we_next       = 1'b0;
    addr_next     = '0;
    wd_next       = '0;

    if (state_reg inside {COUNT, DATA, CSUM})
      timer_next = rx_valid ? '0 : timer_reg + TW'(1);

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (rx_valid && rx_data == START_BYTE) begin
          state_next    = COUNT;
          done_next     = 1'b0;
          err_next      = 1'b0;
          ww_next       = '0;
          csum_next     = '0;
          byte_idx_next = '0;
          word_idx_next = '0;
          asm_next      = '0;
          hold_next     = 1'b1;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          if (count_ok) begin
            count_next = CW'(rx_data);
            state_next = DATA;
          end else begin
            state_next = ERR;
            err_next   = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = ERR;
          err_next   = 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          csum_next     = csum_reg ^ rx_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            we_next   = 1'b1;
            addr_next = 32'(word_idx_reg) << 2;
            wd_next   = word_assembled;
            ww_next   = ww_reg + 7'd1;
            if (word_idx_reg == count_reg - CW'(1))
              state_next = CSUM;
            else
              word_idx_next = word_idx_reg + CW'(1);
          end
        end else if (timeout_hit) begin
          state_next = ERR;
          err_next   = 1'b1;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_reg) begin
            state_next = DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else begin
            state_next = ERR;
            err_next   = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = ERR;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset also drops any write pulse computed in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      asm_reg      <= '0;
      csum_reg     <= '0;
      timer_reg    <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      hold_reg     <= 1'b0;
      ww_reg       <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wd_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      asm_reg      <= asm_next;
      csum_reg     <= csum_next;
      timer_reg    <= timer_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      hold_reg     <= hold_next;
      ww_reg       <= ww_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wd_reg       <= wd_next;
    end
  end

  assign imem_we       = we_reg;
  assign imem_addr     = addr_reg;
  assign imem_wd       = wd_reg;
  assign core_hold     = hold_reg;
  assign busy          = (state_reg == COUNT) || (state_reg == DATA) || (state_reg == CSUM);
  assign done          = done_reg;
  assign err           = err_reg;
  assign words_written = ww_reg;

endmodule
